// File: rtl/reg_dump.sv
// reg_dump: walks a register-file address range through one read port and
// streams each word out over valid/ready, then pulses done with an XOR checksum.
module reg_dump #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] last_q;
    logic              hs;

    assign hs    = out_valid && out_ready;
    // Read port only carries a live address once a dump is running.
    assign raddr = (state == IDLE) ? '0 : ptr;
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state: one FETCH per word, SEND waits for the consumer.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FETCH;
            FETCH:   state_nx = SEND;
            SEND:    if (hs) state_nx = out_last ? DONE : FETCH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: range pointers, output word register and running checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            last_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            checksum  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr      <= first;
                        last_q   <= last;
                        checksum <= '0;
                    end
                end
                FETCH: begin
                    out_data  <= rdata;
                    out_addr  <= ptr;
                    out_last  <= (ptr == last_q);
                    out_valid <= 1'b1;
                end
                SEND: begin
                    if (hs) begin
                        checksum  <= checksum ^ out_data;
                        out_valid <= 1'b0;
                        // Pointer wraps naturally at 2^ADDR_W.
                        if (!out_last) ptr <= ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: register-file model, scoreboard of expected words,
// table of ranges plus backpressure / restart / abort / write sequences.
module tb_reg_dump;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int M_NONE = 0, M_STALL = 1, M_RESTART = 2, M_WR = 3, M_ABORT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] first = '0, last = '0;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          busy, out_valid, out_last, done;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data, checksum;
    logic [AW-1:0] out_addr;

    logic [DW-1:0] rf [16];
    assign rdata = rf[raddr];

    reg_dump #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first(first), .last(last),
        .raddr(raddr), .rdata(rdata), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_last(out_last), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    typedef struct {
        logic [AW-1:0] f;
        logic [AW-1:0] l;
        int            n;
        logic [DW-1:0] sum;
    } vec_t;

    exp_t q[$];
    int   n_cmp = 0, n_err = 0;
    int   cyc = 0;
    int   nwords = 0;
    int   last_hs = -1;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: handshakes pop the scoreboard; stalled words must hold.
    logic          pv = 1'b0;
    logic [DW-1:0] pd;
    logic [AW-1:0] pa;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (pv) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(pd));
                chk("hold_addr", 32'(out_addr), 32'(pa));
            end
            pv = out_valid && !out_ready;
            pd = out_data;
            pa = out_addr;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL extra_word: got addr %0d, expected no word", out_addr);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("word_addr", 32'(out_addr), 32'(e.a));
                    chk("word_data", 32'(out_data), 32'(e.d));
                    chk("word_last", 32'(out_last), 32'(e.l));
                end
                nwords++;
                if (out_last) last_hs = cyc;
            end
            if (done) done_cnt++;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_last"}, 32'(out_last), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_data"}, 32'(out_data), 0);
        chk({tag, "_addr"}, 32'(out_addr), 0);
        chk({tag, "_csum"}, 32'(checksum), 0);
        chk({tag, "_raddr"}, 32'(raddr), 0);
    endtask

    // One dump from f to l; mode selects the corner case injected on the way.
    task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                            input int mode, output int n_exp, output logic [DW-1:0] exp_sum);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int acc, stall_left, got_done, wrote, dcnt0;
        n_exp   = int'(4'(l - f)) + 1;
        exp_sum = '0;
        for (int k = 0; k < n_exp; k++) begin
            a = f + 4'(k);
            d = (mode == M_WR && a == 4'd9) ? 16'hBEEF : rf[a];
            q.push_back('{a: a, d: d, l: (k == n_exp - 1)});
            exp_sum ^= d;
        end
        nwords = 0; last_hs = -1; stall_left = 5; got_done = 0; wrote = 0;
        @(posedge clk); #1;
        start = 1'b1; first = f; last = l;
        @(posedge clk); #1;
        start = 1'b0; acc = cyc;
        first = 4'($urandom); last = 4'($urandom);
        chk("busy_after_start", 32'(busy), 1);
        chk("fetch_raddr", 32'(raddr), 32'(f));
        chk("valid_in_fetch", 32'(out_valid), 0);
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (done) begin got_done = 1; break; end
            @(posedge clk); #1;
            case (mode)
                M_STALL: begin
                    if (out_valid && out_addr == 4'd3 && stall_left > 0) begin
                        out_ready = 1'b0; stall_left--;
                    end else out_ready = 1'b1;
                end
                M_RESTART: begin
                    start = (t == 6);
                    first = 4'd9; last = 4'd9;
                end
                M_WR: begin
                    if (out_valid && out_addr == 4'd4 && !wrote) begin
                        rf[9] = 16'hBEEF; wrote = 1;
                    end
                end
                M_ABORT: begin
                    if (out_valid && out_addr == 4'd7) begin
                        rst_n = 1'b0; #1;
                        check_zero("abort");
                        dcnt0 = done_cnt;
                        repeat (3) @(negedge clk);
                        rst_n = 1'b1;
                        repeat (3) @(negedge clk);
                        chk("abort_no_done", 32'(done_cnt), 32'(dcnt0));
                        chk("abort_idle", 32'(busy), 0);
                        q.delete();
                        return;
                    end
                end
                default: ;
            endcase
        end
        start = 1'b0; out_ready = 1'b1;
        chk("done_seen", 32'(got_done), 1);
        if (!got_done) begin q.delete(); return; end
        chk("done_after_last_hs", 32'(cyc - last_hs), 1);
        chk("word_count", 32'(nwords), 32'(n_exp));
        chk("queue_empty", 32'(q.size()), 0);
        chk("checksum", 32'(checksum), 32'(exp_sum));
        chk("busy_in_done", 32'(busy), 1);
        if (n_exp == 16 && mode == M_NONE)
            chk("full_latency", 32'(last_hs + 1 - acc), 32);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_raddr", 32'(raddr), 0);
        chk("checksum_held", 32'(checksum), 32'(exp_sum));
    endtask

    vec_t vt[6];
    int   n_exp;
    logic [DW-1:0] s;

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = (i == 0) ? 16'h0 : 16'h1000 + 16'(i);
        vt[0] = '{f: 4'd0,  l: 4'd15, n: 16, sum: 16'h1000};
        vt[1] = '{f: 4'd14, l: 4'd1,  n: 4,  sum: 16'h1000};
        vt[2] = '{f: 4'd5,  l: 4'd5,  n: 1,  sum: 16'h1005};
        vt[3] = '{f: 4'd3,  l: 4'd2,  n: 16, sum: 16'h1000};
        vt[4] = '{f: 4'd7,  l: 4'd9,  n: 3,  sum: 16'h1006};
        vt[5] = '{f: 4'd0,  l: 4'd0,  n: 1,  sum: 16'h0000};

        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_reset");

        for (int i = 0; i < 6; i++) begin
            run_dump(vt[i].f, vt[i].l, M_NONE, n_exp, s);
            chk("tbl_count", 32'(nwords), 32'(vt[i].n));
            chk("tbl_checksum", 32'(checksum), 32'(vt[i].sum));
        end

        run_dump(4'd0, 4'd15, M_STALL, n_exp, s);
        chk("stall_checksum", 32'(checksum), 32'h1000);

        run_dump(4'd0, 4'd15, M_RESTART, n_exp, s);
        chk("restart_checksum", 32'(checksum), 32'h1000);

        run_dump(4'd0, 4'd15, M_WR, n_exp, s);
        chk("wr_checksum", 32'(checksum), 32'(16'h1000 ^ 16'h1009 ^ 16'hBEEF));
        rf[9] = 16'h1009;

        run_dump(4'd0, 4'd15, M_ABORT, n_exp, s);
        run_dump(4'd2, 4'd4, M_NONE, n_exp, s);
        chk("fresh_count", 32'(nwords), 3);
        chk("fresh_checksum", 32'(checksum), 32'(16'h1002 ^ 16'h1003 ^ 16'h1004));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
